// File: rtl/brushless_pkg.sv
// -----------------------------------------------------------------------------
// brushless_pkg
// Shared types and constants for the brushless motor commutation controller:
//   phase_e    - per-phase driver code (HiZ / reverse / forward / regen brake)
//   state_e    - controller FSM states
//   sel_t      - the three phase codes bundled as {grn, ylw, blu}
//   DUTY_*     - run base, brake duty and upward slew step
//   STALL_LIM  - unchanged-rotor PWM periods that declare a stall
//   decode_rot - six-step commutation table
//   rot_illegal- flags the impossible hall patterns 000 / 111
// -----------------------------------------------------------------------------
package brushless_pkg;

    typedef enum logic [1:0] {
        PH_HIZ = 2'b00,
        PH_REV = 2'b01,
        PH_FWD = 2'b10,
        PH_BRK = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BRAKE = 2'b10,
        ST_STALL = 2'b11
    } state_e;

    typedef struct packed {
        phase_e grn;
        phase_e ylw;
        phase_e blu;
    } sel_t;

    localparam logic [10:0] DUTY_BASE  = 11'h400;
    localparam logic [10:0] DUTY_BRAKE = 11'h600;
    localparam logic [10:0] DUTY_SLEW  = 11'd16;
    localparam logic [10:0] STALL_LIM  = 11'd1024;

    // Six-step commutation: rot = {Grn,Ylw,Blu}; illegal codes float all phases.
    function automatic sel_t decode_rot(input logic [2:0] rot);
        sel_t s;
        case (rot)
            3'b101:  s = '{PH_FWD, PH_REV, PH_HIZ};
            3'b100:  s = '{PH_FWD, PH_HIZ, PH_REV};
            3'b110:  s = '{PH_HIZ, PH_FWD, PH_REV};
            3'b010:  s = '{PH_REV, PH_FWD, PH_HIZ};
            3'b011:  s = '{PH_REV, PH_HIZ, PH_FWD};
            3'b001:  s = '{PH_HIZ, PH_REV, PH_FWD};
            default: s = '{PH_HIZ, PH_HIZ, PH_HIZ};
        endcase
        return s;
    endfunction

    function automatic logic rot_illegal(input logic [2:0] rot);
        return (rot == 3'b000) || (rot == 3'b111);
    endfunction

endpackage

// File: rtl/brushless_ctrl_hall_sync.sv
// -----------------------------------------------------------------------------
// hall_sync
// Two-flop synchronizer for the asynchronous hall sensor bus.
//   clk   - system clock
//   rst_n - synchronous active-low reset, clears both stages
//   d_i   - W raw asynchronous inputs
//   q_o   - W synchronized outputs (two clocks of latency)
// -----------------------------------------------------------------------------
module hall_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Double-flop metastability filter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/brushless_ctrl.sv
// -----------------------------------------------------------------------------
// brushless_ctrl
// Six-step brushless DC commutation controller with duty slew limiting and
// regenerative braking. Optional stall detector: define HALL_STALL_DET_EN.
// Ports:
//   clk, rst_n               - clock, synchronous active-low reset
//   hallGrn/hallYlw/hallBlu  - asynchronous hall sensors
//   drv_mag[11:0]            - requested drive magnitude (0 = coast)
//   brake_n                  - low requests regen braking
//   PWM_synch                - one-clock strobe at each PWM period start
//   duty[10:0]               - PWM duty to the motor driver
//   selGrn/selYlw/selBlu     - phase codes (00 HiZ, 01 rev, 10 fwd, 11 brake)
//   stall                    - stall fault flag
// Rotor position and duty are only sampled/updated on PWM_synch so the driver
// never sees a commutation or duty change in the middle of a PWM period.
// -----------------------------------------------------------------------------
module brushless_ctrl
    import brushless_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic [11:0] drv_mag,
    input  logic        brake_n,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        stall
);

    logic [2:0]  hall_s;
    logic [2:0]  rot_q, rot_d;
    state_e      state_q, state_d;
    logic [10:0] duty_q, duty_d;
    sel_t        sel_q, sel_d;
    logic        drv_nz_s;
    logic        rot_same_s;
    logic [10:0] target_s;
    logic [10:0] diff_s;

    hall_sync #(.W(3)) u_hall_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({hallGrn, hallYlw, hallBlu}),
        .q_o   (hall_s)
    );

    assign drv_nz_s   = |drv_mag;
    // At a strobe, hall_s is the rotor position about to be latched.
    assign rot_same_s = (hall_s == rot_q);
    assign target_s   = DUTY_BASE + {1'b0, drv_mag[11:2]};
    assign diff_s     = target_s - duty_q;

`ifdef HALL_STALL_DET_EN
    logic [10:0] cnt_q, cnt_d;
    logic        stall_q;
`endif

    // FSM next state; brake overrides every state including STALL.
    always_comb begin
        state_d = state_q;
        if (!brake_n) begin
            state_d = ST_BRAKE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = drv_nz_s ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (!drv_nz_s) begin
                        state_d = ST_IDLE;
`ifdef HALL_STALL_DET_EN
                    end else if (PWM_synch && rot_same_s &&
                                 (cnt_q == STALL_LIM - 11'd1)) begin
                        state_d = ST_STALL;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_BRAKE: state_d = drv_nz_s ? ST_RUN : ST_IDLE;
                ST_STALL: begin
                    if (!drv_nz_s || (PWM_synch && !rot_same_s)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

`ifdef HALL_STALL_DET_EN
    // Count strobes spent in RUN with no rotor movement; any exit from RUN clears.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != ST_RUN) || (state_d != ST_RUN)) begin
            cnt_d = 11'd0;
        end else if (PWM_synch) begin
            cnt_d = rot_same_s ? (cnt_q + 11'd1) : 11'd0;
        end else begin
            cnt_d = cnt_q;
        end
    end
`endif

    // Rotor latch: only refreshed at PWM period start.
    always_comb begin
        rot_d = rot_q;
        if (PWM_synch) begin
            rot_d = hall_s;
        end else begin
            rot_d = rot_q;
        end
    end

    // Duty: brake jumps straight to its level, decreases apply at once,
    // increases are slew-limited to DUTY_SLEW per period.
    always_comb begin
        duty_d = duty_q;
        if (PWM_synch) begin
            if (!brake_n) begin
                duty_d = DUTY_BRAKE;
            end else if ((state_d == ST_STALL) || !drv_nz_s || rot_illegal(hall_s)) begin
                duty_d = 11'd0;
            end else if (target_s > duty_q) begin
                duty_d = duty_q + ((diff_s > DUTY_SLEW) ? DUTY_SLEW : diff_s);
            end else begin
                duty_d = target_s;
            end
        end else begin
            duty_d = duty_q;
        end
    end

    // Phase codes follow the latched rotor one clock later.
    always_comb begin
        sel_d = '{PH_HIZ, PH_HIZ, PH_HIZ};
        if (!brake_n) begin
            sel_d = '{PH_BRK, PH_BRK, PH_BRK};
        end else if ((state_q == ST_STALL) || !drv_nz_s) begin
            sel_d = '{PH_HIZ, PH_HIZ, PH_HIZ};
        end else begin
            sel_d = decode_rot(rot_q);
        end
    end

    // State, rotor, duty and phase registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rot_q   <= 3'b000;
            duty_q  <= 11'd0;
            sel_q   <= '{PH_HIZ, PH_HIZ, PH_HIZ};
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            duty_q  <= duty_d;
            sel_q   <= sel_d;
        end
    end

`ifdef HALL_STALL_DET_EN
    // Stall counter and fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 11'd0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= (state_d == ST_STALL);
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    assign duty   = duty_q;
    assign selGrn = sel_q.grn;
    assign selYlw = sel_q.ylw;
    assign selBlu = sel_q.blu;

endmodule

// File: tb/tb_brushless_ctrl.sv
// -----------------------------------------------------------------------------
// tb_brushless_ctrl
// Directed self-checking bench for brushless_ctrl. A PWM period is modelled as
// one strobe clock followed by two idle clocks; outputs are sampled 1 ns after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_brushless_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hallGrn, hallYlw, hallBlu;
    logic [11:0] drv_mag;
    logic        brake_n;
    logic        PWM_synch;
    logic [10:0] duty;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        stall;

    int tests_run = 0;
    int tests_failed = 0;

    brushless_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hallGrn   (hallGrn),
        .hallYlw   (hallYlw),
        .hallBlu   (hallBlu),
        .drv_mag   (drv_mag),
        .brake_n   (brake_n),
        .PWM_synch (PWM_synch),
        .duty      (duty),
        .selGrn    (selGrn),
        .selYlw    (selYlw),
        .selBlu    (selBlu),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm_period();
        PWM_synch = 1'b1;
        tick(1);
        PWM_synch = 1'b0;
        tick(2);
    endtask

    // Set halls and let them cross the two-flop synchronizer.
    task automatic set_hall(input logic [2:0] h);
        {hallGrn, hallYlw, hallBlu} = h;
        tick(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(1);
        tests_run++;
        if (duty !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_duty: got %h want 000", duty);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_sel: got %b want 000000", {selGrn, selYlw, selBlu});
        end
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_ramp();
        logic [10:0] exp_duty;
        do_reset();
        drv_mag = 12'h800;
        brake_n = 1'b1;
        set_hall(3'b101);
        for (int k = 1; k <= 100; k++) begin
            pwm_period();
            exp_duty = (k >= 96) ? 11'h600 : 11'(16 * k);
            tests_run++;
            if (duty !== exp_duty) begin
                tests_failed++;
                $display("FAIL ramp_duty[%0d]: got %h want %h", k, duty, exp_duty);
            end
            if (k == 1) begin
                tests_run++;
                if ({selGrn, selYlw, selBlu} !== 6'b100100) begin
                    tests_failed++;
                    $display("FAIL ramp_sel: got %b want 100100", {selGrn, selYlw, selBlu});
                end
            end
        end
    endtask

    task automatic test_six_codes();
        logic [2:0] codes [6];
        logic [5:0] exp_sel [6];
        codes   = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        exp_sel = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
        drv_mag = 12'h400;
        brake_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_hall(codes[i]);
            pwm_period();
            tests_run++;
            if ({selGrn, selYlw, selBlu} !== exp_sel[i]) begin
                tests_failed++;
                $display("FAIL six_sel[%b]: got %b want %b", codes[i],
                         {selGrn, selYlw, selBlu}, exp_sel[i]);
            end
            tests_run++;
            if (stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL six_stall[%b]: got %b want 0", codes[i], stall);
            end
        end
    endtask

    task automatic test_brake_mid_ramp();
        do_reset();
        drv_mag = 12'h800;
        brake_n = 1'b1;
        set_hall(3'b101);
        for (int k = 0; k < 5; k++) pwm_period();
        tests_run++;
        if (duty !== 11'd80) begin
            tests_failed++;
            $display("FAIL brake_preramp: got %h want 050", duty);
        end
        brake_n = 1'b0;
        pwm_period();
        tests_run++;
        if (duty !== 11'h600) begin
            tests_failed++;
            $display("FAIL brake_duty: got %h want 600", duty);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b111111) begin
            tests_failed++;
            $display("FAIL brake_sel: got %b want 111111", {selGrn, selYlw, selBlu});
        end
        // Release with a lower demand: target 0x440 must be applied in one step.
        brake_n = 1'b1;
        drv_mag = 12'h100;
        pwm_period();
        tests_run++;
        if (duty !== 11'h440) begin
            tests_failed++;
            $display("FAIL brake_release_duty: got %h want 440", duty);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b100100) begin
            tests_failed++;
            $display("FAIL brake_release_sel: got %b want 100100", {selGrn, selYlw, selBlu});
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [2];
        bad = '{3'b111, 3'b000};
        for (int i = 0; i < 2; i++) begin
            set_hall(bad[i]);
            pwm_period();
            tests_run++;
            if (duty !== 11'd0) begin
                tests_failed++;
                $display("FAIL illegal_duty[%b]: got %h want 000", bad[i], duty);
            end
            tests_run++;
            if ({selGrn, selYlw, selBlu} !== 6'b000000) begin
                tests_failed++;
                $display("FAIL illegal_sel[%b]: got %b want 000000", bad[i],
                         {selGrn, selYlw, selBlu});
            end
        end
    endtask

    task automatic test_zero_mag();
        drv_mag = 12'h000;
        brake_n = 1'b1;
        set_hall(3'b101);
        pwm_period();
        tests_run++;
        if (duty !== 11'd0) begin
            tests_failed++;
            $display("FAIL zero_mag_duty: got %h want 000", duty);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL zero_mag_sel: got %b want 000000", {selGrn, selYlw, selBlu});
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        drv_mag = 12'h800;
        brake_n = 1'b1;
        set_hall(3'b101);
        for (int k = 0; k < 3; k++) pwm_period();
        rst_n = 1'b0;
        tick(1);
        tests_run++;
        if (duty !== 11'd0) begin
            tests_failed++;
            $display("FAIL rst_run_duty: got %h want 000", duty);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL rst_run_sel: got %b want 000000", {selGrn, selYlw, selBlu});
        end
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_run_stall: got %b want 0", stall);
        end
        // Ramp must restart from zero after reset.
        rst_n = 1'b1;
        tick(3);
        pwm_period();
        tests_run++;
        if (duty !== 11'd16) begin
            tests_failed++;
            $display("FAIL rst_run_restart: got %h want 010", duty);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drv_mag = 12'h100;
        brake_n = 1'b1;
        set_hall(3'b101);
        // First strobe latches a new rotor; the next 1024 are unchanged.
        for (int k = 0; k < 1024; k++) pwm_period();
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_early: got %b want 0", stall);
        end
        pwm_period();
`ifdef HALL_STALL_DET_EN
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_set: got %b want 1", stall);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL stall_sel: got %b want 000000", {selGrn, selYlw, selBlu});
        end
        tests_run++;
        if (duty !== 11'd0) begin
            tests_failed++;
            $display("FAIL stall_duty: got %h want 000", duty);
        end
        set_hall(3'b100);
        pwm_period();
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_clear: got %b want 0", stall);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b100001) begin
            tests_failed++;
            $display("FAIL stall_clear_sel: got %b want 100001", {selGrn, selYlw, selBlu});
        end
`else
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_disabled: got %b want 0", stall);
        end
        tests_run++;
        if ({selGrn, selYlw, selBlu} !== 6'b100100) begin
            tests_failed++;
            $display("FAIL stall_disabled_sel: got %b want 100100", {selGrn, selYlw, selBlu});
        end
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        {hallGrn, hallYlw, hallBlu} = 3'b000;
        drv_mag   = 12'h000;
        brake_n   = 1'b1;
        PWM_synch = 1'b0;
        tick(2);
        test_reset();
        test_ramp();
        test_six_codes();
        test_brake_mid_ramp();
        test_illegal();
        test_zero_mag();
        test_reset_mid_run();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/brushless_ctrl.md
BRUSHLESS_CTRL -- requirements
Module: brushless_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst_n input 1 synchronous active-low reset.
REQ-002 SHALL have ports: hallGrn, hallYlw, hallBlu input 1 each, asynchronous hall sensors.
REQ-003 SHALL have ports: drv_mag input 12 unsigned drive magnitude; brake_n input 1, low = regen brake request.
REQ-004 SHALL have port: PWM_synch input 1, one-clk strobe at each PWM period start.
REQ-005 SHALL have ports: duty output 11 to motor driver; selGrn, selYlw, selBlu output 2 each, phase codes.
REQ-006 SHALL have port: stall output 1, stall fault flag.

Function
REQ-007 SHALL use phase codes 00 = HiZ, 01 = reverse current, 10 = forward current, 11 = regen brake.
REQ-008 SHALL pass each hall input through two flops; rot = {Grn,Ylw,Blu} SHALL be latched from synced values only on PWM_synch.
REQ-009 SHALL decode rot to {Grn,Ylw,Blu} codes: 101->10,01,00; 100->10,00,01; 110->00,10,01; 010->01,10,00; 011->01,00,10; 001->00,01,10.
REQ-010 SHALL decode rot 000 or 111 (illegal) to all 00 and hold duty at 0.
REQ-011 SHALL drive all sel = 11 when brake_n = 0, regardless of rot.
REQ-012 SHALL register sel outputs; a hall edge SHALL reach sel 2 clks after sync plus wait to next PWM_synch, plus 1 clk.
REQ-013 SHALL compute target = brake ? 11'h600 : 11'h400 + drv_mag[11:2], in 11 bits, no overflow possible.
REQ-014 SHALL update duty only on PWM_synch.
REQ-015 SHALL slew duty upward by at most 16 per update; downward and brake target SHALL be applied in one update.
REQ-016 SHALL, when drv_mag = 0 and brake_n = 1, set target = 0 and all sel = 00.
REQ-017 SHALL run FSM states IDLE, RUN, BRAKE, STALL.
REQ-018 SHALL take IDLE->RUN when drv_mag != 0; any state->BRAKE when brake_n = 0; BRAKE->IDLE/RUN on brake_n = 1 per drv_mag.
REQ-019 SHALL assert simultaneous brake and stall as BRAKE (brake priority).

Reset
REQ-020 SHALL, on rst_n low at a clk edge, force duty = 0, all sel = 00, stall = 0, state IDLE, rot = 000, sync flops 0, stall counter 0.
REQ-021 SHALL abort operation on reset mid-ramp or mid-stall with no residual state.

Configuration
REQ-022 SHALL compile stall detection in only when HALL_STALL_DET_EN is defined.
REQ-023 SHALL, with HALL_STALL_DET_EN, count PWM_synch strobes in RUN with unchanged rot.
REQ-024 SHALL, with HALL_STALL_DET_EN, enter STALL at 1024 strobes: stall = 1, all sel 00, duty 0.
REQ-025 SHALL, with HALL_STALL_DET_EN, leave STALL to IDLE on rot change or drv_mag = 0, clearing counter and stall.
REQ-026 SHALL, without HALL_STALL_DET_EN, tie stall to 0 and never enter STALL.

Structure
REQ-027 SHALL place phase-code typedef, state enum, duty constants (0x400, 0x600, slew 16) and STALL_LIM in package brushless_pkg.
REQ-028 SHALL implement hall double-flop synchronizer as sub-module hall_sync, instantiated once for 3 bits.

Verification
REQ-029 SHALL cover hall 101, drv_mag 0x800, brake_n 1: after PWM_synch, sel = 10/01/00; duty ramps +16 per period to 0x600.
REQ-030 SHALL cover stepping halls through all six codes: correct sel per REQ-009 each period; stall stays 0.
REQ-031 SHALL cover brake_n low mid-ramp: next PWM_synch gives duty 0x600 and all sel 11.
REQ-032 SHALL cover hall 111: all sel 00, duty 0.
REQ-033 SHALL cover HALL_STALL_DET_EN, rot frozen 1024 periods: stall = 1, sel 00; one hall change clears stall.
REQ-034 SHALL cover rst_n low during RUN: next clk duty 0, sel 00, stall 0.
